ball_motion_ctrl: RTL and testbench
===================================

BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-005 host_chipselect  input  1  host register-port select.
REQ-006 host_write  input  1  host write strobe; a write occurs when host_chipselect, host_write and !host_waitrequest are all 1.
REQ-007 host_address  input  3  host register address.
REQ-008 host_writedata  input  8  host write data.
REQ-009 host_waitrequest  output  1  stalls the host while the engine owns the display port.
REQ-010 disp_chipselect, disp_write  output  1 each  display register-port strobes, always equal to each other.
REQ-011 disp_address  output  3  display register address.
REQ-012 disp_writedata  output  8  display register data.

Function
REQ-013 SHALL forward host writes to addresses 0-6 onto the disp_* port in the cycle after acceptance, registered, as a one-cycle strobe.
REQ-014 SHALL consume host address 7 locally as CTRL and SHALL NOT forward it: bit0 enable, bits[3:1] dx step, bits[6:4] dy step.
REQ-015 SHALL snoop forwarded writes: addr0 updates radius; addr3/addr5 latch the low 5 bits; addr4/addr6 update x/y as {data[4:0], low}.
REQ-016 SHALL set pair_open on an accepted host write to addr3 or addr5, and clear it on an accepted write to addr4 or addr6.
REQ-017 SHALL implement the FSM states IDLE, CALC, WR_XL, WR_XH, WR_YL, WR_YH.
REQ-018 frame_tick SHALL set tick_pend, which is cleared on the IDLE->CALC transition; a tick arriving while tick_pend is set is dropped.
REQ-019 The FSM SHALL leave IDLE for CALC when tick_pend && enable && !pair_open && no host write is accepted that cycle.
REQ-020 Host priority: a host write accepted in the same cycle as the start condition SHALL win, and the burst SHALL start on the next eligible cycle.
REQ-021 CALC SHALL compute the new x and y in one cycle, then step one state per cycle through WR_XL (addr3, x[4:0]), WR_XH (addr4, x[9:5]), WR_YL (addr5, y[4:0]), WR_YH (addr6, y[9:5]), each with upper data bits 0, then return to IDLE.
REQ-022 Burst latency SHALL be: CALC entered at cycle N, display writes at N+1 through N+4.
REQ-023 host_waitrequest SHALL be 1 in CALC and all WR_* states, and 0 in IDLE.
REQ-024 Per-axis arithmetic SHALL use 11 bits unsigned with limits lo = radius and hi = ACTIVE-1-radius (640 for x, 480 for y).
REQ-025 If moving positive and pos+step >= hi: pos = hi and direction flips.
REQ-026 If moving negative and pos <= lo+step: pos = lo and direction flips.
REQ-027 Otherwise pos = pos ± step.
REQ-028 A step of 0 SHALL hold the position, rewrite the same value, and leave the direction unchanged.
REQ-029 If lo > hi (oversized radius), the position SHALL be forced to lo and the direction left unchanged.
REQ-030 Clearing enable mid-burst SHALL NOT abort the burst; it only blocks the next start.

Reset
REQ-031 On reset: FSM to IDLE; all disp_* outputs 0; host_waitrequest 0.
REQ-032 On reset: x = 30, y = 30, radius = 16, both directions positive.
REQ-033 On reset: enable 0, dx = dy = 1, tick_pend 0, pair_open 0, low latches 0.
REQ-034 Reset asserted mid-burst SHALL abort it immediately, with no further display writes.

Structure
REQ-035 Package ball_pkg SHALL hold the FSM state enum, H_ACTIVE = 640, V_ACTIVE = 480, register address constants 0-7, and the reset position and radius.
REQ-036 Sub-module ball_axis_step (pos, dir, step, radius, limit -> new pos, new dir), purely combinational, SHALL be instantiated once per axis.

Verification
REQ-037 Enable with step 1, pulse frame_tick -> writes (3,0x1F), (4,0x00), (5,0x1F), (6,0x00) at cycles N+1 through N+4, with waitrequest high over CALC and all four writes.
REQ-038 x = 622, radius = 16, dx = 3, positive -> new x = 623, direction negative; next tick -> 620.
REQ-039 Host writes addr3 then ticks three frames before writing addr4 -> no burst while pair_open; burst follows the addr4 write, with only one burst (single tick_pend).
REQ-040 Host write coincident with the start condition -> host write forwarded first; burst CALC the following cycle.
REQ-041 Host writes CTRL = 0x00 -> nothing appears on the disp_* port; frame_tick produces no burst.
REQ-042 Reset asserted during WR_XH -> disp_write 0 the next cycle; state IDLE; x = 30.

Source files
------------

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared types and constants for the bouncing-ball motion engine
package ball_pkg;

    // Burst sequencer states: one compute cycle, then four display writes
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_WR_XL = 3'd2,
        ST_WR_XH = 3'd3,
        ST_WR_YL = 3'd4,
        ST_WR_YH = 3'd5
    } state_e;

    // Position registers are 10 bits; axis arithmetic is done at 11 bits so
    // pos+step and ACTIVE-1-radius never wrap.
    localparam int POS_W  = 10;
    localparam int AXIS_W = 11;

    localparam logic [AXIS_W-1:0] H_ACTIVE = 11'd640;
    localparam logic [AXIS_W-1:0] V_ACTIVE = 11'd480;

    // Display register map; CTRL lives only inside this block
    localparam logic [2:0] ADDR_RADIUS = 3'd0;
    localparam logic [2:0] ADDR_REG1   = 3'd1;
    localparam logic [2:0] ADDR_REG2   = 3'd2;
    localparam logic [2:0] ADDR_X_LO   = 3'd3;
    localparam logic [2:0] ADDR_X_HI   = 3'd4;
    localparam logic [2:0] ADDR_Y_LO   = 3'd5;
    localparam logic [2:0] ADDR_Y_HI   = 3'd6;
    localparam logic [2:0] ADDR_CTRL   = 3'd7;

    localparam logic [POS_W-1:0] RESET_X      = 10'd30;
    localparam logic [POS_W-1:0] RESET_Y      = 10'd30;
    localparam logic [7:0]       RESET_RADIUS = 8'd16;

    // Display coordinate registers carry 5 bits; the upper data bits are zero
    function automatic logic [7:0] coord_byte(input logic [4:0] field);
        return {3'b000, field};
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-axis position/direction update with wall bounce
module ball_axis_step
    import ball_pkg::*;
(
    input  logic [POS_W-1:0]  pos,
    input  logic              dir,
    input  logic [2:0]        step,
    input  logic [7:0]        radius,
    input  logic [AXIS_W-1:0] limit,
    output logic [POS_W-1:0]  new_pos,
    output logic              new_dir
);

    logic [AXIS_W-1:0] lo;
    logic [AXIS_W-1:0] hi;
    logic [AXIS_W-1:0] pos_w;
    logic [AXIS_W-1:0] step_w;
    logic [AXIS_W-1:0] pos_plus;
    logic [AXIS_W-1:0] pos_minus;
    logic [AXIS_W-1:0] lo_plus;

    // Walls sit one radius in from each screen edge so the ball stays visible
    assign lo        = {3'b000, radius};
    assign hi        = limit - 11'd1 - lo;
    assign pos_w     = {1'b0, pos};
    assign step_w    = {8'd0, step};
    assign pos_plus  = pos_w + step_w;
    assign pos_minus = pos_w - step_w;
    assign lo_plus   = lo + step_w;

    // Pick next position: oversized ball pins to lo, zero step holds, else move or bounce
    always_comb begin
        new_pos = pos;
        new_dir = dir;
        if (lo > hi) begin
            new_pos = lo[POS_W-1:0];
        end else if (step == 3'd0) begin
            new_pos = pos;
        end else if (dir) begin
            if (pos_plus >= hi) begin
                new_pos = hi[POS_W-1:0];
                new_dir = 1'b0;
            end else begin
                new_pos = pos_plus[POS_W-1:0];
            end
        end else begin
            if (pos_w <= lo_plus) begin
                new_pos = lo[POS_W-1:0];
                new_dir = 1'b1;
            end else begin
                new_pos = pos_minus[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - host pass-through plus per-frame ball position writer
module ball_motion_ctrl
    import ball_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       host_chipselect,
    input  logic       host_write,
    input  logic [2:0] host_address,
    input  logic [7:0] host_writedata,
    output logic       host_waitrequest,
    output logic       disp_chipselect,
    output logic       disp_write,
    output logic [2:0] disp_address,
    output logic [7:0] disp_writedata
);

    state_e           state_q, state_d;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic [7:0]       radius_q, radius_d;
    logic             enable_q, enable_d;
    logic [2:0]       dx_q, dx_d;
    logic [2:0]       dy_q, dy_d;
    logic             tick_pend_q, tick_pend_d;
    logic             pair_open_q, pair_open_d;
    logic [4:0]       low_x_q, low_x_d;
    logic [4:0]       low_y_q, low_y_d;
    logic             disp_we_q, disp_we_d;
    logic [2:0]       disp_addr_q, disp_addr_d;
    logic [7:0]       disp_data_q, disp_data_d;
    logic             wait_q, wait_d;

    logic             host_accept;
    logic             start_burst;
    logic [POS_W-1:0] x_next;
    logic [POS_W-1:0] y_next;
    logic             dir_x_next;
    logic             dir_y_next;

    // Host owns the display port whenever the engine is idle
    assign host_accept = host_chipselect & host_write & ~wait_q;

    // A half-written coordinate pair or a same-cycle host write defers the burst
    assign start_burst = (state_q == ST_IDLE) & tick_pend_q & enable_q &
                         ~pair_open_q & ~host_accept;

    ball_axis_step u_step_x (
        .pos     (x_q),
        .dir     (dir_x_q),
        .step    (dx_q),
        .radius  (radius_q),
        .limit   (H_ACTIVE),
        .new_pos (x_next),
        .new_dir (dir_x_next)
    );

    ball_axis_step u_step_y (
        .pos     (y_q),
        .dir     (dir_y_q),
        .step    (dy_q),
        .radius  (radius_q),
        .limit   (V_ACTIVE),
        .new_pos (y_next),
        .new_dir (dir_y_next)
    );

    // Next-state: host forwarding and snooping, then the burst sequencer
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        radius_d    = radius_q;
        enable_d    = enable_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        tick_pend_d = tick_pend_q | frame_tick;
        pair_open_d = pair_open_q;
        low_x_d     = low_x_q;
        low_y_d     = low_y_q;
        disp_we_d   = 1'b0;
        disp_addr_d = 3'd0;
        disp_data_d = 8'd0;

        if (host_accept) begin
            if (host_address == ADDR_CTRL) begin
                enable_d = host_writedata[0];
                dx_d     = host_writedata[3:1];
                dy_d     = host_writedata[6:4];
            end else begin
                disp_we_d   = 1'b1;
                disp_addr_d = host_address;
                disp_data_d = host_writedata;
                case (host_address)
                    ADDR_RADIUS: radius_d = host_writedata;
                    ADDR_X_LO: begin
                        low_x_d     = host_writedata[4:0];
                        pair_open_d = 1'b1;
                    end
                    ADDR_X_HI: begin
                        x_d         = {host_writedata[4:0], low_x_q};
                        pair_open_d = 1'b0;
                    end
                    ADDR_Y_LO: begin
                        low_y_d     = host_writedata[4:0];
                        pair_open_d = 1'b1;
                    end
                    ADDR_Y_HI: begin
                        y_d         = {host_writedata[4:0], low_y_q};
                        pair_open_d = 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_burst) begin
                    state_d     = ST_CALC;
                    tick_pend_d = 1'b0;
                end
            end
            ST_CALC: begin
                x_d         = x_next;
                y_d         = y_next;
                dir_x_d     = dir_x_next;
                dir_y_d     = dir_y_next;
                state_d     = ST_WR_XL;
                disp_we_d   = 1'b1;
                disp_addr_d = ADDR_X_LO;
                disp_data_d = coord_byte(x_next[4:0]);
            end
            ST_WR_XL: begin
                state_d     = ST_WR_XH;
                disp_we_d   = 1'b1;
                disp_addr_d = ADDR_X_HI;
                disp_data_d = coord_byte(x_q[9:5]);
            end
            ST_WR_XH: begin
                state_d     = ST_WR_YL;
                disp_we_d   = 1'b1;
                disp_addr_d = ADDR_Y_LO;
                disp_data_d = coord_byte(y_q[4:0]);
            end
            ST_WR_YL: begin
                state_d     = ST_WR_YH;
                disp_we_d   = 1'b1;
                disp_addr_d = ADDR_Y_HI;
                disp_data_d = coord_byte(y_q[9:5]);
            end
            ST_WR_YH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stall the host for every cycle the engine is out of IDLE
        wait_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= RESET_X;
            y_q         <= RESET_Y;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            radius_q    <= RESET_RADIUS;
            enable_q    <= 1'b0;
            dx_q        <= 3'd1;
            dy_q        <= 3'd1;
            tick_pend_q <= 1'b0;
            pair_open_q <= 1'b0;
            low_x_q     <= 5'd0;
            low_y_q     <= 5'd0;
            disp_we_q   <= 1'b0;
            disp_addr_q <= 3'd0;
            disp_data_q <= 8'd0;
            wait_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            radius_q    <= radius_d;
            enable_q    <= enable_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            tick_pend_q <= tick_pend_d;
            pair_open_q <= pair_open_d;
            low_x_q     <= low_x_d;
            low_y_q     <= low_y_d;
            disp_we_q   <= disp_we_d;
            disp_addr_q <= disp_addr_d;
            disp_data_q <= disp_data_d;
            wait_q      <= wait_d;
        end
    end

    assign host_waitrequest = wait_q;
    assign disp_chipselect  = disp_we_q;
    assign disp_write       = disp_we_q;
    assign disp_address     = disp_addr_q;
    assign disp_writedata   = disp_data_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - self-checking bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       host_chipselect;
    logic       host_write;
    logic [2:0] host_address;
    logic [7:0] host_writedata;
    logic       host_waitrequest;
    logic       disp_chipselect;
    logic       disp_write;
    logic [2:0] disp_address;
    logic [7:0] disp_writedata;

    int checks   = 0;
    int failures = 0;

    // Reference model of the ball and register state
    int mx, my, mrad, msx, msy, mlowx, mlowy;
    bit mdx, mdy, men, mpend, mpair;

    ball_motion_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .host_chipselect  (host_chipselect),
        .host_write       (host_write),
        .host_address     (host_address),
        .host_writedata   (host_writedata),
        .host_waitrequest (host_waitrequest),
        .disp_chipselect  (disp_chipselect),
        .disp_write       (disp_write),
        .disp_address     (disp_address),
        .disp_writedata   (disp_writedata)
    );

    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 30; my = 30; mrad = 16; msx = 1; msy = 1;
        mdx = 1; mdy = 1; men = 0; mpend = 0; mpair = 0;
        mlowx = 0; mlowy = 0;
    endtask

    task automatic model_axis(inout int pos, inout bit dir, input int step, input int rad, input int active);
        int lo, hi;
        lo = rad;
        hi = active - 1 - rad;
        if (lo > hi) pos = lo;
        else if (step == 0) begin end
        else if (dir) begin
            if (pos + step >= hi) begin pos = hi; dir = !dir; end
            else pos = pos + step;
        end else begin
            if (pos <= lo + step) begin pos = lo; dir = !dir; end
            else pos = pos - step;
        end
    endtask

    task automatic host_drive(input int a, input int d);
        host_chipselect = 1'b1;
        host_write      = 1'b1;
        host_address    = a[2:0];
        host_writedata  = d[7:0];
        @(posedge clk); #1;
        host_chipselect = 1'b0;
        host_write      = 1'b0;
        if (a == 7) begin
            chk("ctrl_not_forwarded", {disp_chipselect, disp_write}, 0);
            men = d[0];
            msx = (d >> 1) & 7;
            msy = (d >> 4) & 7;
        end else begin
            chk("fwd_strobe", {disp_chipselect, disp_write}, 2'b11);
            chk("fwd_addr", disp_address, a);
            chk("fwd_data", disp_writedata, d & 255);
            case (a)
                0: mrad = d & 255;
                3: begin mlowx = d & 31; mpair = 1; end
                4: begin mx = ((d & 31) << 5) | mlowx; mpair = 0; end
                5: begin mlowy = d & 31; mpair = 1; end
                6: begin my = ((d & 31) << 5) | mlowy; mpair = 0; end
                default: begin end
            endcase
        end
    endtask

    task automatic host_wr(input int a, input int d);
        @(posedge clk); #1;
        host_drive(a, d);
    endtask

    task automatic tick_pulse();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        mpend = 1;
    endtask

    task automatic check_burst();
        int ea[4];
        int ed[4];
        model_axis(mx, mdx, msx, mrad, 640);
        model_axis(my, mdy, msy, mrad, 480);
        mpend = 0;
        ea = '{3, 4, 5, 6};
        ed = '{mx & 31, mx >> 5, my & 31, my >> 5};
        @(posedge clk); #1;
        chk("calc_wait_nowrite", {host_waitrequest, disp_write}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("burst_wait", host_waitrequest, 1);
            chk("burst_strobe", {disp_chipselect, disp_write}, 2'b11);
            chk("burst_addr", disp_address, ea[i]);
            chk("burst_data", disp_writedata, ed[i]);
        end
        @(posedge clk); #1;
        chk("burst_end", {host_waitrequest, disp_write}, 2'b00);
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_quiet", {host_waitrequest, disp_write, disp_chipselect}, 0);
        end
    endtask

    task automatic settle();
        if (mpend && men && !mpair) check_burst();
        else check_idle(3);
    endtask

    initial begin
        int op, v, d;
        reset           = 1'b1;
        frame_tick      = 1'b0;
        host_chipselect = 1'b0;
        host_write      = 1'b0;
        host_address    = 3'd0;
        host_writedata  = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp_write", disp_write, 0);
        chk("rst_disp_cs", disp_chipselect, 0);
        chk("rst_disp_addr", disp_address, 0);
        chk("rst_disp_data", disp_writedata, 0);
        chk("rst_waitrequest", host_waitrequest, 0);
        @(negedge clk) reset = 1'b0;

        // Enable with unit steps: first burst writes 31 to both axes
        host_wr(7, 'h13);
        settle();
        tick_pulse();
        chk("pre_calc_wait_low", host_waitrequest, 0);
        settle();

        // Bounce off the right wall: 622 -> 623 (flip) -> 620
        host_wr(3, 622 & 31);
        settle();
        host_wr(4, 622 >> 5);
        settle();
        host_wr(7, 'h17);
        settle();
        tick_pulse();
        settle();
        tick_pulse();
        settle();

        // Open pair blocks bursts; ticks collapse into one pending burst
        host_wr(3, 5);
        settle();
        repeat (3) begin
            tick_pulse();
            settle();
        end
        host_wr(4, 6);
        settle();
        check_idle(8);

        // Host write coincident with the start condition goes first
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        mpend = 1;
        host_drive(1, 'h5A);
        chk("coincident_wait_low", host_waitrequest, 0);
        settle();

        // CTRL = 0: nothing forwarded, tick produces no burst, re-enable starts it
        host_wr(7, 0);
        settle();
        tick_pulse();
        settle();
        check_idle(5);
        host_wr(7, 'h13);
        settle();

        // Randomized register traffic and frames
        repeat (40) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    d = (($urandom_range(0, 3) != 0) ? 1 : 0) | ($urandom_range(0, 7) << 1) |
                        ($urandom_range(0, 7) << 4) | ($urandom_range(0, 1) << 7);
                    host_wr(7, d);
                    settle();
                end
                1: begin
                    v = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 60);
                    host_wr(0, v);
                    settle();
                end
                2: begin
                    v = $urandom_range(0, 1023);
                    host_wr(3, (v & 31) | ($urandom_range(0, 7) << 5));
                    settle();
                    host_wr(4, (v >> 5) | ($urandom_range(0, 7) << 5));
                    settle();
                end
                3: begin
                    v = $urandom_range(0, 1023);
                    host_wr(5, (v & 31) | ($urandom_range(0, 7) << 5));
                    settle();
                    host_wr(6, (v >> 5) | ($urandom_range(0, 7) << 5));
                    settle();
                end
                4: begin
                    host_wr($urandom_range(1, 2), $urandom_range(0, 255));
                    settle();
                end
                default: begin
                    tick_pulse();
                    settle();
                end
            endcase
        end

        // Reset during WR_XH aborts the burst and restores x = 30
        host_wr(0, 16);
        settle();
        host_wr(7, 'h03);
        settle();
        tick_pulse();
        @(posedge clk); #1;
        chk("abort_calc_wait", host_waitrequest, 1);
        @(posedge clk); #1;
        chk("abort_wr_xl_addr", {disp_write, disp_address}, {1'b1, 3'd3});
        @(posedge clk); #1;
        chk("abort_wr_xh_addr", {disp_write, disp_address}, {1'b1, 3'd4});
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_quiet", {host_waitrequest, disp_write, disp_chipselect}, 0);
        chk("abort_addr", disp_address, 0);
        @(negedge clk) reset = 1'b0;
        model_reset();
        check_idle(3);
        host_wr(7, 'h01);
        settle();
        tick_pulse();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
